pyc_stream_downsizer: RTL and testbench
=======================================

// Module: pyc_stream_downsizer
// PURPOSE
//  Ready/valid width down-converter (serializer). Accepts wide words and emits them as
//  OUT_WIDTH beats, LSB slice first. It is the narrow-side counterpart of our packing and
//  CDC stream blocks, and typically drains a wide FIFO into a narrow consumer.
//  A one-entry skid register breaks the combinational path from out_ready to in_ready.
// PARAMETERS
//  OUT_WIDTH  8  width of one output beat in bits (>=1)
//  RATIO      4  output beats per input word; must be a power of two and >=2
//                (IW = OUT_WIDTH*RATIO, CW = clog2(RATIO))
// PORTS
//  clk        in   1          single clock; all state on posedge
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          input word valid
//  in_ready   out  1          input word accepted when in_valid && in_ready
//  in_data    in   IW         word; beat k = in_data[k*OUT_WIDTH +: OUT_WIDTH]
//  in_nbeats  in   CW         number of beats to emit, minus 1 (0 = 1 beat .. RATIO-1 = all)
//  in_last    in   1          word ends a packet
//  out_valid  out  1          output beat valid
//  out_ready  in   1          beat consumed when out_valid && out_ready
//  out_data   out  OUT_WIDTH  current beat
//  out_last   out  1          final beat of a word whose in_last was 1
//  busy       out  1          active or skid register occupied
// BEHAVIOUR
//  - State: ACTIVE reg (shift data, remaining count, last flag, valid) + SKID reg (word, nbeats, last, valid).
//  - Reset (async, rst_n=0): both valids=0, data/counts=0. out_valid=0, out_data=0, out_last=0,
//    busy=0, in_ready=1. A reset asserted mid-word drops in-flight data immediately; no beat resumes.
//  - in_ready = ~skid_valid. It is driven from a register only, with no path from out_ready.
//  - pop = out_valid && out_ready. fin = pop && remaining==0 (final beat of the active word).
//  - free = !active_valid || fin.
//  - On accept (in_valid && in_ready):
//      free && !skid_valid -> load ACTIVE directly (remaining=in_nbeats); no bubble.
//      otherwise           -> load SKID.
//  - On fin with skid_valid -> ACTIVE loads from SKID in the same cycle; skid_valid clears.
//    in_ready is 0 that cycle, so there is no concurrent accept.
//  - On fin with nothing to load -> active_valid=0.
//  - On pop && remaining!=0: shift data right by OUT_WIDTH, remaining -= 1.
//  - out_valid = active_valid. out_data = active_data[OUT_WIDTH-1:0] when valid, else 0.
//  - out_last = active_valid && active_last && remaining==0.
//  - busy = active_valid || skid_valid.
//  - Latency: a word accepted at edge N presents its first beat from edge N (after N, out_valid=1).
//  - Throughput: with out_ready held at 1, full words emit RATIO beats back to back with no idle
//    cycles between words.
//  - Stall: while out_valid && !out_ready, out_data, out_last and remaining hold stable.
//    in_ready may drop only when the skid fills.
//  - remaining arithmetic is CW bits wide. in_nbeats selects a prefix of beats; upper slices are
//    discarded, never emitted.
//  - Simultaneous accept + fin with empty skid: new word goes to ACTIVE, old word completes.
// TESTING
//  1. Reset: rst_n=0 with in_valid=1 -> out_valid=0, out_data=0, in_ready=1, busy=0.
//     Deassert -> first accept ok.
//  2. Single word 0xDDCCBBAA, nbeats=3, last=1, out_ready=1 -> beats AA,BB,CC,DD on 4
//     consecutive cycles; out_last=1 only on DD.
//  3. Back-to-back words 0x44332211 and 0x88776655 with out_ready=1 -> 8 beats 11..88,
//     no gaps; in_ready never drops combinationally.
//  4. Backpressure: out_ready=0 for 10 cycles after beat 1 -> out_data holds 0x22.
//     Second word fills skid, in_ready=0, third word is not accepted until the first word finishes.
//  5. Partial word 0xDDCCBBAA, nbeats=1, last=1 -> beats AA,BB only, out_last=1 on BB, then
//     out_valid=0.
//  6. rst_n pulsed low mid-word (after beat 2 of 4) -> out_valid=0 asynchronously.
//     After release no stale beats appear and the next word starts at its beat 0.

Source files
------------

// File: rtl/pyc_stream_downsizer_if.sv
// Stream bundle for the downsizer: wide input side, narrow output side and a busy flag.
interface pyc_stream_downsizer_if #(
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned RATIO     = 4
);
    localparam int unsigned IW = OUT_WIDTH * RATIO;
    localparam int unsigned CW = $clog2(RATIO);

    logic                 in_valid;
    logic                 in_ready;
    logic [IW-1:0]        in_data;
    logic [CW-1:0]        in_nbeats;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic                 busy;

    modport slave (
        input  in_valid, in_data, in_nbeats, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

    modport master (
        output in_valid, in_data, in_nbeats, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/pyc_stream_downsizer.sv
// Wide-to-narrow stream serializer, LSB beat first, with a one-word skid register
// so that in_ready depends only on local state.
module pyc_stream_downsizer #(
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned RATIO     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pyc_stream_downsizer_if.slave bus_if
);
    localparam int unsigned IW = OUT_WIDTH * RATIO;
    localparam int unsigned CW = $clog2(RATIO);

    logic [IW-1:0] act_data_q,  act_data_d;
    logic [CW-1:0] act_rem_q,   act_rem_d;
    logic          act_last_q,  act_last_d;
    logic          act_valid_q, act_valid_d;
    logic [IW-1:0] skid_data_q,   skid_data_d;
    logic [CW-1:0] skid_nbeats_q, skid_nbeats_d;
    logic          skid_last_q,   skid_last_d;
    logic          skid_valid_q,  skid_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          out_last_q, out_last_d;
    logic          busy_q,     busy_d;

    logic pop, fin, free, accept;

    // Next-state: shift/retire the active word, refill from skid, then take a new word.
    always_comb begin
        act_data_d    = act_data_q;
        act_rem_d     = act_rem_q;
        act_last_d    = act_last_q;
        act_valid_d   = act_valid_q;
        skid_data_d   = skid_data_q;
        skid_nbeats_d = skid_nbeats_q;
        skid_last_d   = skid_last_q;
        skid_valid_d  = skid_valid_q;

        pop    = act_valid_q && bus_if.out_ready;
        fin    = pop && (act_rem_q == '0);
        free   = !act_valid_q || fin;
        accept = bus_if.in_valid && in_ready_q;

        if (pop && (act_rem_q != '0)) begin
            act_data_d = act_data_q >> OUT_WIDTH;
            act_rem_d  = act_rem_q - CW'(1);
        end

        if (fin) begin
            if (skid_valid_q) begin
                act_data_d   = skid_data_q;
                act_rem_d    = skid_nbeats_q;
                act_last_d   = skid_last_q;
                act_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                // Cleared so the idle beat output reads as zero straight from the register.
                act_data_d  = '0;
                act_rem_d   = '0;
                act_last_d  = 1'b0;
                act_valid_d = 1'b0;
            end
        end

        // accept implies an empty skid, so it never collides with the skid refill above.
        if (accept) begin
            if (free && !skid_valid_q) begin
                act_data_d  = bus_if.in_data;
                act_rem_d   = bus_if.in_nbeats;
                act_last_d  = bus_if.in_last;
                act_valid_d = 1'b1;
            end else begin
                skid_data_d   = bus_if.in_data;
                skid_nbeats_d = bus_if.in_nbeats;
                skid_last_d   = bus_if.in_last;
                skid_valid_d  = 1'b1;
            end
        end

        in_ready_d = !skid_valid_d;
        out_last_d = act_valid_d && act_last_d && (act_rem_d == '0);
        busy_d     = act_valid_d || skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data_q    <= '0;
            act_rem_q     <= '0;
            act_last_q    <= 1'b0;
            act_valid_q   <= 1'b0;
            skid_data_q   <= '0;
            skid_nbeats_q <= '0;
            skid_last_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            in_ready_q    <= 1'b1;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            act_data_q    <= act_data_d;
            act_rem_q     <= act_rem_d;
            act_last_q    <= act_last_d;
            act_valid_q   <= act_valid_d;
            skid_data_q   <= skid_data_d;
            skid_nbeats_q <= skid_nbeats_d;
            skid_last_q   <= skid_last_d;
            skid_valid_q  <= skid_valid_d;
            in_ready_q    <= in_ready_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
        end
    end

    assign bus_if.in_ready  = in_ready_q;
    assign bus_if.out_valid = act_valid_q;
    assign bus_if.out_data  = act_data_q[OUT_WIDTH-1:0];
    assign bus_if.out_last  = out_last_q;
    assign bus_if.busy      = busy_q;
endmodule

// File: tb/tb_pyc_stream_downsizer.sv
// Directed and random checks of pyc_stream_downsizer against a queue-based beat model.
module tb_pyc_stream_downsizer;
    localparam int unsigned OW = 8;
    localparam int unsigned R  = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pops;

    logic [OW:0] beat_q[$];   // {last, data} of every beat still owed
    int          word_q[$];   // beats still owed per held word

    pyc_stream_downsizer_if #(.OUT_WIDTH(OW), .RATIO(R)) bus ();

    pyc_stream_downsizer #(.OUT_WIDTH(OW), .RATIO(R)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare outputs against the model at the falling edge, then advance one clock.
    task automatic cycle(output bit acc);
        bit          pp;
        logic [31:0] d;
        int          nb;
        logic        l;
        logic [OW:0] b;
        chk("out_valid", 32'(bus.out_valid), 32'(beat_q.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(word_q.size() < 2));
        chk("busy", 32'(bus.busy), 32'(word_q.size() != 0));
        if (bus.out_valid && beat_q.size() != 0) begin
            b = beat_q[0];
            chk("out_data", 32'(bus.out_data), 32'(b[OW-1:0]));
            chk("out_last", 32'(bus.out_last), 32'(b[OW]));
        end
        acc = bus.in_valid && bus.in_ready;
        pp  = bus.out_valid && bus.out_ready;
        d   = bus.in_data;
        nb  = int'(bus.in_nbeats);
        l   = bus.in_last;
        @(posedge clk);
        if (pp && beat_q.size() != 0) begin
            void'(beat_q.pop_front());
            word_q[0] = word_q[0] - 1;
            if (word_q[0] == 0) void'(word_q.pop_front());
            pops++;
        end
        if (acc) begin
            for (int k = 0; k <= nb; k++)
                beat_q.push_back({(l && k == nb), d[k*OW +: OW]});
            word_q.push_back(nb + 1);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input int nb, input logic l);
        bit acc;
        int n;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_nbeats = 2'(nb);
        bus.in_last   = l;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            cycle(acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (beat_q.size() != 0 && n < 100) begin
            cycle(acc);
            n++;
        end
        chk("drain_empty", 32'(beat_q.size()), 32'd0);
        cycle(acc);
    endtask

    initial begin
        bit acc;
        int p0;
        checks = 0;
        errors = 0;
        pops   = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h12345678;
        bus.in_nbeats = 2'd3;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;

        // Reset with in_valid high: nothing taken, outputs idle.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single full word.
        send(32'hDDCCBBAA, 3, 1'b1);
        chk("t2_first_beat", 32'(bus.out_data), 32'hAA);
        drain();

        // Back-to-back words must stream with no gaps.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h44332211;
        bus.in_nbeats = 2'd3;
        bus.in_last   = 1'b0;
        cycle(acc);
        chk("t3_acc1", 32'(acc), 32'd1);
        bus.in_data = 32'h88776655;
        bus.in_last = 1'b1;
        cycle(acc);
        chk("t3_acc2", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        p0 = pops;
        repeat (7) cycle(acc);
        chk("t3_no_gaps", 32'(pops - p0), 32'd7);
        drain();

        // Backpressure: stall after beat 1, skid fills, third word waits.
        send(32'h44332211, 3, 1'b1);
        bus.out_ready = 1'b1;
        cycle(acc);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h88776655;
        bus.in_last   = 1'b0;
        cycle(acc);
        chk("t4_skid_acc", 32'(acc), 32'd1);
        bus.in_data = 32'hCCBBAA99;
        bus.in_last = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle(acc);
            if (acc) chk("t4_third_early", 32'(acc), 32'd0);
        end
        chk("t4_hold_data", 32'(bus.out_data), 32'h22);
        chk("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        p0 = 0;
        acc = 1'b0;
        while (!acc && p0 < 20) begin
            cycle(acc);
            p0++;
        end
        chk("t4_third_accepted", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        drain();

        // Partial word: two beats only.
        send(32'hDDCCBBAA, 1, 1'b1);
        drain();
        chk("t5_idle", 32'(bus.out_valid), 32'd0);

        // Reset mid-word drops the remainder at once.
        send(32'hDDCCBBAA, 3, 1'b1);
        bus.out_ready = 1'b1;
        cycle(acc);
        cycle(acc);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_async_data", 32'(bus.out_data), 32'd0);
        chk("t6_async_busy", 32'(bus.busy), 32'd0);
        beat_q.delete();
        word_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h0D0C0B0A, 3, 1'b0);
        chk("t6_restart_beat0", 32'(bus.out_data), 32'h0A);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = $urandom;
            bus.in_nbeats = 2'($urandom_range(0, R - 1));
            bus.in_last   = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
